intersection_phase_scheduler: RTL

//  Synthesizable phase scheduler for the highway/country intersection.

---
 rtl/intersection_phase_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// Highway/country intersection phase scheduler with a latched pedestrian request.
// Moore FSM: lights decode the registered state; dwell times come from one in-state timer.
module intersection_phase_scheduler #(
    parameter int CNT_W     = 4,
    parameter int MIN_GREEN = 8,
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MAX_CR    = 10,
    parameter int WALK_TIME = 6
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] highway_road,
    output logic [1:0] country_road,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // A state with dwell D is left on the edge where timer == D-1.
    localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y2R_LAST       = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] R2G_LAST       = CNT_W'(R2G_DELAY - 1);
    localparam logic [CNT_W-1:0] MAX_CR_LAST    = CNT_W'(MAX_CR - 1);
    localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_TIME - 1);

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALL_RED   = 3'd2,
        CR_GREEN  = 3'd3,
        CR_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             from_hw_q, from_hw_d;
    logic             ped_pending_q, ped_pending_d;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= HW_GREEN;
            timer_q       <= '0;
            from_hw_q     <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            from_hw_q     <= from_hw_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        from_hw_d = from_hw_q;
        case (state_q)
            HW_GREEN: begin
                if (timer_q >= MIN_GREEN_LAST && (x || ped_pending_q))
                    state_d = HW_YELLOW;
            end
            HW_YELLOW: begin
                if (timer_q == Y2R_LAST) begin
                    state_d   = ALL_RED;
                    from_hw_d = 1'b1;
                end
            end
            ALL_RED: begin
                // Pedestrian wins over the country car; after a country green the highway returns.
                if (timer_q == R2G_LAST) begin
                    if (!from_hw_q)
                        state_d = HW_GREEN;
                    else if (ped_pending_q)
                        state_d = PED_WALK;
                    else if (x)
                        state_d = CR_GREEN;
                    else
                        state_d = HW_GREEN;
                end
            end
            CR_GREEN: begin
                if (!x || timer_q == MAX_CR_LAST)
                    state_d = CR_YELLOW;
            end
            CR_YELLOW: begin
                if (timer_q == Y2R_LAST) begin
                    state_d   = ALL_RED;
                    from_hw_d = 1'b0;
                end
            end
            PED_WALK: begin
                if (timer_q == WALK_LAST)
                    state_d = ALL_RED;
            end
            default: begin
                state_d   = HW_GREEN;
                from_hw_d = 1'b0;
            end
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (&timer_q)
            timer_d = timer_q;
        else
            timer_d = timer_q + 1'b1;

        // Presses during the walk, or on the edge entering it, are dropped.
        if (state_q == PED_WALK || state_d == PED_WALK)
            ped_pending_d = 1'b0;
        else
            ped_pending_d = ped_pending_q | ped_req;
    end

    always_comb begin
        highway_road = RED;
        country_road = RED;
        walk         = 1'b0;
        case (state_q)
            HW_GREEN:  highway_road = GREEN;
            HW_YELLOW: highway_road = YELLOW;
            CR_GREEN:  country_road = GREEN;
            CR_YELLOW: country_road = YELLOW;
            PED_WALK:  walk         = 1'b1;
            default:   ;
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule
